// File: rtl/bnn_psum_array.sv
// Binary-NN PE array: weights held per output channel, psums held per (channel, pixel) entry.
// Saturating accumulate on every activation; popped entries read out in order and cleared.
module bnn_psum_array #(
  parameter int KBITS   = 9,
  parameter int OCH     = 64,
  parameter int ROW_LEN = 4,
  parameter int PSUM_W  = 14
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [KBITS-1:0]         data_in,
  input  logic                     load_weight_in,
  input  logic                     in_valid_in,
  input  logic                     pop_in,
  output logic signed [PSUM_W-1:0] sum_out,
  output logic                     sum_valid_out,
  output logic                     pop_done_out,
  output logic                     sat_out,
  output logic                     err_out
);

  localparam int NENT = OCH * ROW_LEN;
  localparam int WIW  = (OCH > 1) ? $clog2(OCH) : 1;
  localparam int AIW  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int PIW  = (NENT > 1) ? $clog2(NENT) : 1;
  // Wide enough that psum + contribution never wraps before the clamp test.
  localparam int SW   = PSUM_W + $clog2(KBITS + 1) + 2;
  localparam logic signed [SW-1:0] PMAX = SW'((1 << (PSUM_W - 1)) - 1);
  localparam logic signed [SW-1:0] PMIN = SW'(-(1 << (PSUM_W - 1)));

  logic [KBITS-1:0]         weight [OCH];
  logic signed [PSUM_W-1:0] psum   [NENT];
  logic [WIW-1:0]           widx;
  logic [AIW-1:0]           aidx;
  logic [PIW-1:0]           pidx;

  logic [PIW-1:0]           acc_idx [OCH];
  logic signed [SW-1:0]     acc_raw [OCH];
  logic signed [PSUM_W-1:0] acc_nxt [OCH];
  logic [OCH-1:0]           acc_clip;

  // XNOR-popcount mapped to a +/-1 dot product: matches minus mismatches.
  function automatic logic signed [SW-1:0] contrib(input logic [KBITS-1:0] w,
                                                   input logic [KBITS-1:0] a);
    logic [KBITS-1:0] m;
    int n;
    m = ~(w ^ a);
    n = 0;
    for (int i = 0; i < KBITS; i++) n += 32'(m[i]);
    return SW'(2 * n - KBITS);
  endfunction

  always_comb begin
    for (int o = 0; o < OCH; o++) begin
      acc_idx[o]  = PIW'(o * ROW_LEN) + PIW'(aidx);
      acc_raw[o]  = SW'(psum[acc_idx[o]]) + contrib(weight[o], data_in);
      acc_clip[o] = 1'b0;
      acc_nxt[o]  = acc_raw[o][PSUM_W-1:0];
      if (acc_raw[o] > PMAX) begin
        acc_nxt[o]  = PMAX[PSUM_W-1:0];
        acc_clip[o] = 1'b1;
      end else if (acc_raw[o] < PMIN) begin
        acc_nxt[o]  = PMIN[PSUM_W-1:0];
        acc_clip[o] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int o = 0; o < OCH; o++) weight[o] <= '0;
      for (int p = 0; p < NENT; p++) psum[p] <= '0;
      widx          <= '0;
      aidx          <= '0;
      pidx          <= '0;
      sum_out       <= '0;
      sum_valid_out <= 1'b0;
      pop_done_out  <= 1'b0;
      sat_out       <= 1'b0;
      err_out       <= 1'b0;
    end else begin
      sum_valid_out <= 1'b0;
      pop_done_out  <= 1'b0;
      if (load_weight_in) begin
        weight[widx] <= data_in;
        widx         <= (widx == WIW'(OCH - 1)) ? '0 : widx + WIW'(1);
        aidx         <= '0;
        if (in_valid_in || pop_in) err_out <= 1'b1;
      end else if (in_valid_in) begin
        for (int o = 0; o < OCH; o++) psum[acc_idx[o]] <= acc_nxt[o];
        if (|acc_clip) sat_out <= 1'b1;
        aidx <= (aidx == AIW'(ROW_LEN - 1)) ? '0 : aidx + AIW'(1);
        widx <= '0;
        if (pop_in) err_out <= 1'b1;
      end else if (pop_in) begin
        sum_out       <= psum[pidx];
        psum[pidx]    <= '0;
        sum_valid_out <= 1'b1;
        pop_done_out  <= (pidx == PIW'(NENT - 1));
        pidx          <= (pidx == PIW'(NENT - 1)) ? '0 : pidx + PIW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bnn_psum_array.sv
// Directed bench: default-size array for function/collision/reset, small PSUM_W array for clamping.
module tb_bnn_psum_array;

  localparam int KBITS = 9;
  localparam int OCH   = 64;
  localparam int RL    = 4;
  localparam int NENT  = OCH * RL;
  localparam int B_OCH = 2;
  localparam int B_N   = B_OCH * RL;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [KBITS-1:0] a_data;
  logic             a_load, a_valid, a_pop;
  logic signed [13:0] a_sum;
  logic             a_sv, a_done, a_sat, a_err;

  logic [KBITS-1:0] b_data;
  logic             b_load, b_valid, b_pop;
  logic signed [4:0] b_sum;
  logic             b_sv, b_done, b_sat, b_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bnn_psum_array #(.KBITS(KBITS), .OCH(OCH), .ROW_LEN(RL), .PSUM_W(14)) dut_a (
    .clk_in(clk), .rst_in(rst), .data_in(a_data),
    .load_weight_in(a_load), .in_valid_in(a_valid), .pop_in(a_pop),
    .sum_out(a_sum), .sum_valid_out(a_sv), .pop_done_out(a_done),
    .sat_out(a_sat), .err_out(a_err)
  );

  bnn_psum_array #(.KBITS(KBITS), .OCH(B_OCH), .ROW_LEN(RL), .PSUM_W(5)) dut_b (
    .clk_in(clk), .rst_in(rst), .data_in(b_data),
    .load_weight_in(b_load), .in_valid_in(b_valid), .pop_in(b_pop),
    .sum_out(b_sum), .sum_valid_out(b_sv), .pop_done_out(b_done),
    .sat_out(b_sat), .err_out(b_err)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_load_w(input logic [KBITS-1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      a_data = d; a_load = 1'b1; step();
    end
    a_load = 1'b0;
  endtask

  task automatic a_act(input logic [KBITS-1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      a_data = d; a_valid = 1'b1; step();
    end
    a_valid = 1'b0;
  endtask

  // Full readout; e0 is the expected value for channel 0, erest for every other channel.
  task automatic a_pop_pass(input string tag, input int e0, input int erest);
    int wrong, nvalid, done_at, ev;
    wrong = 0; nvalid = 0; done_at = -1;
    for (int p = 0; p < NENT; p++) begin
      a_pop = 1'b1; step();
      ev = (p < RL) ? e0 : erest;
      if (a_sv) nvalid++;
      if (int'(a_sum) != ev) wrong++;
      if (a_done) done_at = (done_at == -1) ? p : -2;
    end
    a_pop = 1'b0; step();
    check({tag, "_wrong_entries"}, wrong, 0);
    check({tag, "_valid_cycles"}, nvalid, NENT);
    check({tag, "_done_pos"}, done_at, NENT - 1);
    check({tag, "_idle_valid"}, int'(a_sv), 0);
  endtask

  task automatic b_step(input logic ld, input logic vl, input logic pp,
                        input logic [KBITS-1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      b_data = d; b_load = ld; b_valid = vl; b_pop = pp; step();
    end
    b_load = 1'b0; b_valid = 1'b0; b_pop = 1'b0;
  endtask

  task automatic b_pop_pass(input string tag, input int ev);
    int wrong, done_at;
    wrong = 0; done_at = -1;
    for (int p = 0; p < B_N; p++) begin
      b_pop = 1'b1; step();
      if (!b_sv || int'(b_sum) != ev) wrong++;
      if (b_done) done_at = (done_at == -1) ? p : -2;
    end
    b_pop = 1'b0; step();
    check({tag, "_wrong_entries"}, wrong, 0);
    check({tag, "_done_pos"}, done_at, B_N - 1);
  endtask

  initial begin
    a_data = '0; a_load = 1'b0; a_valid = 1'b0; a_pop = 1'b0;
    b_data = '0; b_load = 1'b0; b_valid = 1'b0; b_pop = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sum", int'(a_sum), 0);
    check("rst_valid", int'(a_sv), 0);
    check("rst_done", int'(a_done), 0);
    check("rst_sat", int'(a_sat), 0);
    check("rst_err", int'(a_err), 0);
    rst = 1'b0;
    step();

    a_load_w(9'h1FF, OCH); a_act(9'h1FF, RL);
    a_pop_pass("one_ch", 9, 9);

    repeat (3) begin
      a_load_w(9'h000, OCH); a_act(9'h1FF, RL);
    end
    a_pop_pass("three_ch", -27, -27);
    a_pop_pass("cleared", 0, 0);

    a_load_w(9'h00F, OCH); a_act(9'h000, RL);
    a_pop_pass("mixed", 1, 1);
    a_load_w(9'h1FF, 1); a_load_w(9'h00F, OCH - 1); a_act(9'h000, RL);
    a_pop_pass("row0", -9, 1);

    check("err_clean", int'(a_err), 0);
    // Last weight arrives together with an activation: weight wins, activation dropped.
    a_load_w(9'h1FF, OCH - 1);
    a_data = 9'h1FF; a_load = 1'b1; a_valid = 1'b1; step();
    a_load = 1'b0; a_valid = 1'b0;
    check("err_set", int'(a_err), 1);
    a_act(9'h1FF, RL);
    a_pop_pass("coll_load", 9, 9);

    for (int i = 0; i < RL; i++) begin
      a_data = 9'h1FF; a_valid = 1'b1; a_pop = 1'b1; step();
      check("coll_pop_valid", int'(a_sv), 0);
    end
    a_valid = 1'b0; a_pop = 1'b0;
    a_pop_pass("coll_pop", 9, 9);

    a_act(9'h1FF, RL);
    a_pop = 1'b1; step(); step(); step();
    check("pre_rst_valid", int'(a_sv), 1);
    check("pre_rst_sum", int'(a_sum), 9);
    #2 rst = 1'b1;
    #1;
    check("midrst_sum", int'(a_sum), 0);
    check("midrst_valid", int'(a_sv), 0);
    check("midrst_done", int'(a_done), 0);
    check("midrst_err", int'(a_err), 0);
    a_pop = 1'b0;
    step();
    rst = 1'b0;
    step();
    a_pop_pass("after_rst", 0, 0);
    check("sat_a_never", int'(a_sat), 0);

    b_step(1'b1, 1'b0, 1'b0, 9'h1FF, B_OCH);
    b_step(1'b0, 1'b1, 1'b0, 9'h1FF, RL);
    check("sat_b_below", int'(b_sat), 0);
    b_step(1'b0, 1'b1, 1'b0, 9'h1FF, RL);
    check("sat_b_set", int'(b_sat), 1);
    b_pop_pass("b_pos_clamp", 15);
    b_pop_pass("b_cleared", 0);
    check("sat_b_sticky", int'(b_sat), 1);
    b_step(1'b1, 1'b0, 1'b0, 9'h000, B_OCH);
    b_step(1'b0, 1'b1, 1'b0, 9'h1FF, 2 * RL);
    b_pop_pass("b_neg_clamp", -16);
    check("err_b_clean", int'(b_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bnn_psum_array.md
# bnn_psum_array

Parametrised binary-neural-network PE array: weight-stationary across output channels, output-stationary across a row of output pixels. It replaces the fixed 64-channel, 4-pixel, 14-bit array with configurable kernel width, channel count, row length and psum width. New relative to the fixed array: saturating accumulation, clear-on-pop readout with a registered valid strobe, self-aligning load indices, and collision/saturation status flags. It sits between the on-chip activation/weight streamer (single shared `data_in` bus) and the output writeback path.

## Interface
- KBITS, 9, bits per binary kernel/activation word (3x3 window)
- OCH, 64, output channels (PE rows)
- ROW_LEN, 4, output pixels per PE row
- PSUM_W, 14, signed psum width
- clk_in  in  1  clock, all state on rising edge
- rst_in  in  1  asynchronous, active-high reset
- data_in  in  KBITS  weight word or activation word
- load_weight_in  in  1  write data_in to weight[widx]
- in_valid_in  in  1  data_in is activation for pixel aidx; accumulate into all OCH rows
- pop_in  in  1  read and clear psum[pidx]
- sum_out  out  PSUM_W  signed psum read by previous pop
- sum_valid_out  out  1  sum_out valid this cycle
- pop_done_out  out  1  one-cycle pulse with the last entry (pidx = OCH*ROW_LEN-1)
- sat_out  out  1  sticky: any accumulation saturated
- err_out  out  1  sticky: request collision occurred

## Operation
- Storage: weight[OCH] x KBITS; psum[OCH][ROW_LEN] x PSUM_W signed; counters widx (0..OCH-1), aidx (0..ROW_LEN-1), pidx (0..OCH*ROW_LEN-1).
- Priority per cycle: load_weight_in > in_valid_in > pop_in. Any lower-priority request asserted together with a higher one is dropped and sets err_out.
- Weight load: weight[widx] <= data_in; widx wraps OCH-1 -> 0; aidx <= 0.
- Activation: for every o, contribution c_o = 2*popcount(~(weight[o] ^ data_in)) - KBITS (range -KBITS..+KBITS). psum[o][aidx] <= sat(psum[o][aidx] + c_o). aidx wraps ROW_LEN-1 -> 0; widx <= 0.
- Saturation: clamp to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1]; on clamp set sat_out.
- Pop: entry p = o*ROW_LEN + c, popped in increasing p. Register sum_out <= psum[p], then clear psum[p] <= 0. pidx wraps to 0 after the last entry.
- Channel accumulation: psums persist across weight/activation groups until popped or reset; no clear between groups.
- sat_out and err_out clear only on reset.

## Timing
- Reset (async assert, sync-safe release): all weights, psums, counters 0; sum_out=0, sum_valid_out=0, pop_done_out=0, sat_out=0, err_out=0.
- Weight write and psum accumulate take effect at the same edge the request is sampled. An activation in the cycle right after a weight load uses the new weight.
- Pop latency 1: pop_in sampled at edge t -> sum_out/sum_valid_out valid from t until t+1. Back-to-back pops give one entry per cycle. sum_out holds its last value when sum_valid_out=0.
- pop_done_out is coincident with sum_valid_out for the last entry.
- Pop of an entry being accumulated in the same cycle cannot occur (priority). A dropped pop does not advance pidx.
- Reset mid-pop: pidx returns to 0 and all psums are lost; no partial state survives.

## Test plan
- Reset: assert rst_in mid-stream with nonzero psums -> all outputs 0 immediately; a following 256-entry pop returns all 0.
- Single channel (defaults): 64 weights 9'h1FF, 4 activations 9'h1FF, 256 pops -> every sum_out = +9, sum_valid_out high 256 cycles, pop_done_out on the 256th only.
- Three channels: 3x (64 weights 9'h000, 4 activations 9'h1FF), pop -> every entry -27. A second immediate pop pass -> all 0 (clear-on-pop).
- Mixed match: weight[o]=9'b000001111 for all o, activation 9'h000 -> 5 matches -> +1 per pixel; weight[0]=9'h1FF only -> row 0 = -9, others +1.
- Saturation (PSUM_W=5, range -16..15): two channels of +9 -> entries 15, sat_out=1 and stays 1 until reset.
- Collision: load_weight_in and in_valid_in high together -> weight written, no psum change, err_out=1. pop_in with in_valid_in -> accumulation happens, no sum_valid_out, pidx unchanged.
